// File: rtl/subtrator_serial.sv
// subtrator_serial: sequential adder/subtractor working K bits per clock.
//
// Operands are captured on an accepted start request and processed least
// significant chunk first through a single K-bit adder slice. After N/K
// cycles the result lands in S and fim pulses for one cycle. A start request
// held during the done cycle is accepted immediately (back-to-back).
//
// Optional feature: define SUBTRATOR_SERIAL_OVF_EN to add the ovf port
// (signed overflow of the N-bit operation, updated together with S).
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous active-high reset
//   inicio   in   1    start request
//   modo     in   1    0 = A - B, 1 = A + B
//   A        in   N    minuend / augend
//   B        in   N    subtrahend / addend
//   ocupado  out  1    high while not idle
//   fim      out  1    one-cycle done pulse
//   S        out  N+1  result; S[N] = borrow-out (sub) or carry-out (add)
//   ovf      out  1    signed overflow (SUBTRATOR_SERIAL_OVF_EN only)
module subtrator_serial #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic         modo,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ocupado,
    output logic         fim,
    output logic [N:0]   S
`ifdef SUBTRATOR_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned Chunks = N / K;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

    if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_param_check
        $error("subtrator_serial: need N >= 2, 1 <= K <= N and N a multiple of K");
    end

    typedef enum logic [1:0] {StOcioso, StCalcula, StFim} state_e;

    state_e          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    res_q;
    logic            modo_q;
    logic            carry_q;
    logic [CntW-1:0] cnt_q;

    logic [K-1:0]    b_chunk;
    logic [K:0]      sum;
    logic [N-1:0]    res_next;
    logic            last;

    // One K-bit slice: subtract is A + ~B + 1, the +1 coming from the carry preset.
    always_comb begin
        b_chunk = modo_q ? b_q[K-1:0] : ~b_q[K-1:0];
        sum     = {1'b0, a_q[K-1:0]} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
        last    = (cnt_q == CntW'(Chunks - 1));
    end

    // Result fills from the top so the last chunk ends up in the MSBs.
    if (K < N) begin : g_res_shift
        assign res_next = {sum[K-1:0], res_q[N-1:K]};
    end else begin : g_res_full
        assign res_next = sum[K-1:0];
    end

`ifdef SUBTRATOR_SERIAL_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit, XOR carry out.
    logic ovf_next;
    assign ovf_next = a_q[K-1] ^ b_chunk[K-1] ^ sum[K-1] ^ sum[K];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOcioso;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            modo_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ocupado <= 1'b0;
            fim     <= 1'b0;
            S       <= '0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            fim <= 1'b0;
            unique case (state_q)
                StCalcula: begin
                    a_q     <= a_q >> K;
                    b_q     <= b_q >> K;
                    res_q   <= res_next;
                    carry_q <= sum[K];
                    cnt_q   <= cnt_q + CntW'(1);
                    if (last) begin
                        state_q <= StFim;
                        fim     <= 1'b1;
                        // Borrow-out is the inverted carry in subtract mode.
                        S       <= {(modo_q ? sum[K] : ~sum[K]), res_next};
`ifdef SUBTRATOR_SERIAL_OVF_EN
                        ovf     <= ovf_next;
`endif
                    end
                end
                // Idle and done behave alike: accept a start or go/stay idle.
                default: begin
                    if (inicio) begin
                        state_q <= StCalcula;
                        a_q     <= A;
                        b_q     <= B;
                        modo_q  <= modo;
                        carry_q <= ~modo;
                        cnt_q   <= '0;
                        ocupado <= 1'b1;
                    end else begin
                        state_q <= StOcioso;
                        ocupado <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
